// File: rtl/line_mem_bridge.sv
// Bridges one cache line fill or writeback at a time onto a beat-wide burst memory bus.
// Writes take priority over reads arriving in the same cycle so a writeback always precedes its refill.
module line_mem_bridge #(
    parameter  int BYTES_PER_LINE = 64,
    parameter  int BEAT_WIDTH     = 64,
    localparam int LINE_BITS      = BYTES_PER_LINE * 8,
    localparam int BEATS          = LINE_BITS / BEAT_WIDTH,
    localparam int OFFSET_SIZE    = $clog2(BYTES_PER_LINE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [63:0]           S_R_ADDR,
    input  logic                  S_R_ADDR_VALID,
    output logic [LINE_BITS-1:0]  S_R_DATA,
    output logic                  S_R_DATA_VALID,
    input  logic                  S_W_VALID,
    input  logic [63:0]           S_W_ADDR,
    input  logic [LINE_BITS-1:0]  S_W_DATA,
    output logic                  S_W_READY,
    output logic                  S_W_COMPLETE,
    output logic [63:0]           M_ADDR,
    output logic                  M_ADDR_VALID,
    input  logic                  M_ADDR_READY,
    output logic                  M_WRITE,
    output logic [BEAT_WIDTH-1:0] M_WDATA,
    output logic                  M_WDATA_VALID,
    input  logic                  M_WDATA_READY,
    input  logic [BEAT_WIDTH-1:0] M_RDATA,
    input  logic                  M_RDATA_VALID,
    input  logic                  M_BVALID
);

    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE, R_ADDR, R_DATA, R_DONE, W_ADDR, W_DATA, W_RESP, W_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [63:0]           r_addr;
    logic [LINE_BITS-1:0]  r_line;
    logic [LINE_BITS-1:0]  r_rdata;
    logic [BEAT_WIDTH-1:0] w_beat [BEATS];
    logic                  w_last;

    function automatic logic [63:0] align(input logic [63:0] addr);
        return {addr[63:OFFSET_SIZE], {OFFSET_SIZE{1'b0}}};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            assign w_beat[gi] = r_line[gi*BEAT_WIDTH +: BEAT_WIDTH];
        end
    endgenerate

    assign w_last   = (r_cnt == LAST_BEAT);
    assign S_R_DATA = r_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        S_W_READY      = 1'b0;
        S_R_DATA_VALID = 1'b0;
        S_W_COMPLETE   = 1'b0;
        M_ADDR         = '0;
        M_ADDR_VALID   = 1'b0;
        M_WRITE        = 1'b0;
        M_WDATA        = '0;
        M_WDATA_VALID  = 1'b0;
        case (r_state)
            IDLE: begin
                S_W_READY = 1'b1;
                if (S_W_VALID) begin
                    w_state_next = W_ADDR;
                end else if (S_R_ADDR_VALID) begin
                    w_state_next = R_ADDR;
                end
            end
            R_ADDR: begin
                M_ADDR_VALID = 1'b1;
                M_ADDR       = r_addr;
                if (M_ADDR_READY) w_state_next = R_DATA;
            end
            R_DATA: begin
                if (M_RDATA_VALID && w_last) w_state_next = R_DONE;
            end
            R_DONE: begin
                S_R_DATA_VALID = 1'b1;
                w_state_next   = IDLE;
            end
            W_ADDR: begin
                M_ADDR_VALID = 1'b1;
                M_WRITE      = 1'b1;
                M_ADDR       = r_addr;
                if (M_ADDR_READY) w_state_next = W_DATA;
            end
            W_DATA: begin
                M_WDATA_VALID = 1'b1;
                M_WDATA       = w_beat[r_cnt];
                if (M_WDATA_READY && w_last) w_state_next = W_RESP;
            end
            W_RESP: begin
                if (M_BVALID) w_state_next = W_DONE;
            end
            W_DONE: begin
                S_W_COMPLETE = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // r_line carries the writeback line or the fill under assembly; r_rdata only changes when a fill completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_line  <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (S_W_VALID) begin
                        r_addr <= align(S_W_ADDR);
                        r_line <= S_W_DATA;
                    end else if (S_R_ADDR_VALID) begin
                        r_addr <= align(S_R_ADDR);
                    end
                end
                R_DATA: begin
                    if (M_RDATA_VALID) begin
                        r_line[r_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= M_RDATA;
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_rdata <= {M_RDATA, r_line[LINE_BITS-BEAT_WIDTH-1:0]};
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                W_DATA: begin
                    if (M_WDATA_READY) begin
                        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
